ex_mem_pipe: RTL and testbench

EX_MEM_PIPE -- requirements
Module: ex_mem_pipe

---
 rtl/ex_mem_pkg.sv | 25 ++
 rtl/ex_mem_slot.sv | 56 +++++
 rtl/ex_mem_pipe.sv | 208 ++++++++++++++++++++
 tb/tb_ex_mem_pipe.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg: shared definitions for the EX/MEM pipeline register.
//   - pipe_state_t : occupancy state of the two-entry elastic buffer
//   - MS_*         : funct3 memory access-size/sign codes
//   - fwd_ok()     : whether a head entry's result may be forwarded to EX
package ex_mem_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_t;

    localparam logic [2:0] MS_BYTE   = 3'b000;
    localparam logic [2:0] MS_HALF   = 3'b001;
    localparam logic [2:0] MS_WORD   = 3'b010;
    localparam logic [2:0] MS_BYTE_U = 3'b100;
    localparam logic [2:0] MS_HALF_U = 3'b101;

    // A load's value is not known until the memory returns data, so only
    // non-load register writes are forwardable from this stage.
    function automatic logic fwd_ok(input logic reg_write, input logic mem_re);
        return reg_write & ~mem_re;
    endfunction

endpackage

// File: rtl/ex_mem_slot.sv
// ex_mem_slot: one EX/MEM entry (data + control fields) with load enable.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset (clears all fields)
//   i_load         : capture the i_* fields on the rising edge
//   i_* / o_*      : ALU result, store data, rd, control bits, size code
module ex_mem_slot
    import ex_mem_pkg::*;
#(
    parameter int D_WIDTH  = 32,
    parameter int RF_SIZE  = 5,
    parameter int MS_WIDTH = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_load,
    input  logic [D_WIDTH-1:0]  i_alu,
    input  logic [D_WIDTH-1:0]  i_rs2,
    input  logic [RF_SIZE-1:0]  i_rd,
    input  logic                i_reg_write,
    input  logic                i_mem_we,
    input  logic                i_mem_re,
    input  logic                i_mem_to_reg,
    input  logic [MS_WIDTH-1:0] i_mem_size,
    output logic [D_WIDTH-1:0]  o_alu,
    output logic [D_WIDTH-1:0]  o_rs2,
    output logic [RF_SIZE-1:0]  o_rd,
    output logic                o_reg_write,
    output logic                o_mem_we,
    output logic                o_mem_re,
    output logic                o_mem_to_reg,
    output logic [MS_WIDTH-1:0] o_mem_size
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_alu        <= '0;
            o_rs2        <= '0;
            o_rd         <= '0;
            o_reg_write  <= 1'b0;
            o_mem_we     <= 1'b0;
            o_mem_re     <= 1'b0;
            o_mem_to_reg <= 1'b0;
            o_mem_size   <= '0;
        end else if (i_load) begin
            o_alu        <= i_alu;
            o_rs2        <= i_rs2;
            o_rd         <= i_rd;
            o_reg_write  <= i_reg_write;
            o_mem_we     <= i_mem_we;
            o_mem_re     <= i_mem_re;
            o_mem_to_reg <= i_mem_to_reg;
            o_mem_size   <= i_mem_size;
        end
    end

endmodule

// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe: EX/MEM pipeline register as a 2-entry elastic buffer
// (main + skid) with valid/ready handshakes on both sides.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   flush                    : drop every held entry (and a same-cycle accept)
//   in_valid / in_ready      : EX-side handshake
//   *_ex                     : instruction fields from EX
//   out_valid / out_ready    : MEM-side handshake
//   *_mem                    : head entry, control bits gated by out_valid
//   fwd_valid/fwd_rd/fwd_val : EX forwarding from the head entry
// in_ready/out_valid come straight from the state register, so there is no
// combinational path from either input handshake to the other side.
module ex_mem_pipe
    import ex_mem_pkg::*;
#(
    parameter int D_WIDTH  = 32,
    parameter int RF_SIZE  = 5,
    parameter int MS_WIDTH = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [D_WIDTH-1:0]  alu_out_ex,
    input  logic [D_WIDTH-1:0]  rs2_val_ex,
    input  logic [RF_SIZE-1:0]  rd_ex,
    input  logic                reg_write_ex,
    input  logic                mem_we_ex,
    input  logic                mem_re_ex,
    input  logic                mem_to_reg_ex,
    input  logic [MS_WIDTH-1:0] mem_size_ex,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [D_WIDTH-1:0]  alu_out_mem,
    output logic [D_WIDTH-1:0]  rs2_val_mem,
    output logic [RF_SIZE-1:0]  rd_mem,
    output logic                reg_write_mem,
    output logic                mem_we_mem,
    output logic                mem_re_mem,
    output logic                mem_to_reg_mem,
    output logic [MS_WIDTH-1:0] mem_size_mem,
    output logic                fwd_valid,
    output logic [RF_SIZE-1:0]  fwd_rd,
    output logic [D_WIDTH-1:0]  fwd_val
);

    pipe_state_t r_state;
    pipe_state_t w_state_nxt;

    logic w_accept;
    logic w_consume;
    logic w_load_main;
    logic w_load_skid;
    logic w_main_from_skid;
    logic w_in_reg_write;

    // Skid slot outputs
    logic [D_WIDTH-1:0]  w_sk_alu;
    logic [D_WIDTH-1:0]  w_sk_rs2;
    logic [RF_SIZE-1:0]  w_sk_rd;
    logic                w_sk_rw;
    logic                w_sk_we;
    logic                w_sk_re;
    logic                w_sk_m2r;
    logic [MS_WIDTH-1:0] w_sk_size;

    // Main slot inputs (muxed between EX and skid)
    logic [D_WIDTH-1:0]  w_mn_alu;
    logic [D_WIDTH-1:0]  w_mn_rs2;
    logic [RF_SIZE-1:0]  w_mn_rd;
    logic                w_mn_rw;
    logic                w_mn_we;
    logic                w_mn_re;
    logic                w_mn_m2r;
    logic [MS_WIDTH-1:0] w_mn_size;

    // Main slot outputs (ungated)
    logic                w_hd_rw;
    logic                w_hd_we;
    logic                w_hd_re;
    logic                w_hd_m2r;

    assign in_ready  = (r_state != ST_FULL);
    assign out_valid = (r_state != ST_EMPTY);
    assign w_accept  = in_valid & in_ready;
    assign w_consume = out_valid & out_ready;

    // x0 is hardwired zero, so a write to it is dropped at capture.
    assign w_in_reg_write = reg_write_ex & (rd_ex != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main      = 1'b0;
        w_load_skid      = 1'b0;
        w_main_from_skid = 1'b0;
        unique case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = ST_ONE;
                    w_load_main = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_accept && w_consume) begin
                    w_load_main = 1'b1;
                end else if (w_accept) begin
                    w_state_nxt = ST_FULL;
                    w_load_skid = 1'b1;
                end else if (w_consume) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_consume) begin
                    w_state_nxt      = ST_ONE;
                    w_load_main      = 1'b1;
                    w_main_from_skid = 1'b1;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
        if (flush) begin
            w_state_nxt = ST_EMPTY;
            w_load_main = 1'b0;
            w_load_skid = 1'b0;
        end
    end

    assign w_mn_alu  = w_main_from_skid ? w_sk_alu  : alu_out_ex;
    assign w_mn_rs2  = w_main_from_skid ? w_sk_rs2  : rs2_val_ex;
    assign w_mn_rd   = w_main_from_skid ? w_sk_rd   : rd_ex;
    assign w_mn_rw   = w_main_from_skid ? w_sk_rw   : w_in_reg_write;
    assign w_mn_we   = w_main_from_skid ? w_sk_we   : mem_we_ex;
    assign w_mn_re   = w_main_from_skid ? w_sk_re   : mem_re_ex;
    assign w_mn_m2r  = w_main_from_skid ? w_sk_m2r  : mem_to_reg_ex;
    assign w_mn_size = w_main_from_skid ? w_sk_size : mem_size_ex;

    ex_mem_slot #(
        .D_WIDTH (D_WIDTH),
        .RF_SIZE (RF_SIZE),
        .MS_WIDTH(MS_WIDTH)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load_skid),
        .i_alu       (alu_out_ex),
        .i_rs2       (rs2_val_ex),
        .i_rd        (rd_ex),
        .i_reg_write (w_in_reg_write),
        .i_mem_we    (mem_we_ex),
        .i_mem_re    (mem_re_ex),
        .i_mem_to_reg(mem_to_reg_ex),
        .i_mem_size  (mem_size_ex),
        .o_alu       (w_sk_alu),
        .o_rs2       (w_sk_rs2),
        .o_rd        (w_sk_rd),
        .o_reg_write (w_sk_rw),
        .o_mem_we    (w_sk_we),
        .o_mem_re    (w_sk_re),
        .o_mem_to_reg(w_sk_m2r),
        .o_mem_size  (w_sk_size)
    );

    ex_mem_slot #(
        .D_WIDTH (D_WIDTH),
        .RF_SIZE (RF_SIZE),
        .MS_WIDTH(MS_WIDTH)
    ) u_main (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load_main),
        .i_alu       (w_mn_alu),
        .i_rs2       (w_mn_rs2),
        .i_rd        (w_mn_rd),
        .i_reg_write (w_mn_rw),
        .i_mem_we    (w_mn_we),
        .i_mem_re    (w_mn_re),
        .i_mem_to_reg(w_mn_m2r),
        .i_mem_size  (w_mn_size),
        .o_alu       (alu_out_mem),
        .o_rs2       (rs2_val_mem),
        .o_rd        (rd_mem),
        .o_reg_write (w_hd_rw),
        .o_mem_we    (w_hd_we),
        .o_mem_re    (w_hd_re),
        .o_mem_to_reg(w_hd_m2r),
        .o_mem_size  (mem_size_mem)
    );

    assign reg_write_mem  = out_valid & w_hd_rw;
    assign mem_we_mem     = out_valid & w_hd_we;
    assign mem_re_mem     = out_valid & w_hd_re;
    assign mem_to_reg_mem = out_valid & w_hd_m2r;

    assign fwd_valid = out_valid & fwd_ok(w_hd_rw, w_hd_re);
    assign fwd_rd    = rd_mem;
    assign fwd_val   = alu_out_mem;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// tb_ex_mem_pipe: self-checking bench for ex_mem_pipe. A queue-based model
// (at most two entries, FIFO order) predicts the MEM-side outputs; a compare
// process checks them every negedge. Directed scenarios add literal checks.
module tb_ex_mem_pipe;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int MW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] alu_out_ex = '0;
    logic [DW-1:0] rs2_val_ex = '0;
    logic [RW-1:0] rd_ex = '0;
    logic          reg_write_ex = 1'b0;
    logic          mem_we_ex = 1'b0;
    logic          mem_re_ex = 1'b0;
    logic          mem_to_reg_ex = 1'b0;
    logic [MW-1:0] mem_size_ex = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] alu_out_mem;
    logic [DW-1:0] rs2_val_mem;
    logic [RW-1:0] rd_mem;
    logic          reg_write_mem;
    logic          mem_we_mem;
    logic          mem_re_mem;
    logic          mem_to_reg_mem;
    logic [MW-1:0] mem_size_mem;
    logic          fwd_valid;
    logic [RW-1:0] fwd_rd;
    logic [DW-1:0] fwd_val;

    ex_mem_pipe #(.D_WIDTH(DW), .RF_SIZE(RW), .MS_WIDTH(MW)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .alu_out_ex    (alu_out_ex),
        .rs2_val_ex    (rs2_val_ex),
        .rd_ex         (rd_ex),
        .reg_write_ex  (reg_write_ex),
        .mem_we_ex     (mem_we_ex),
        .mem_re_ex     (mem_re_ex),
        .mem_to_reg_ex (mem_to_reg_ex),
        .mem_size_ex   (mem_size_ex),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .alu_out_mem   (alu_out_mem),
        .rs2_val_mem   (rs2_val_mem),
        .rd_mem        (rd_mem),
        .reg_write_mem (reg_write_mem),
        .mem_we_mem    (mem_we_mem),
        .mem_re_mem    (mem_re_mem),
        .mem_to_reg_mem(mem_to_reg_mem),
        .mem_size_mem  (mem_size_mem),
        .fwd_valid     (fwd_valid),
        .fwd_rd        (fwd_rd),
        .fwd_val       (fwd_val)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] alu;
        logic [DW-1:0] rs2;
        logic [RW-1:0] rd;
        logic          rw;
        logic          we;
        logic          re;
        logic          m2r;
        logic [MW-1:0] size;
    } entry_t;

    entry_t q[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO of at most two instructions.
    always @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            q.delete();
        end else begin
            int     n;
            bit     acc;
            bit     con;
            entry_t e;
            n   = q.size();
            acc = in_valid && (n < 2);
            con = out_ready && (n > 0);
            e.alu  = alu_out_ex;
            e.rs2  = rs2_val_ex;
            e.rd   = rd_ex;
            e.rw   = reg_write_ex && (rd_ex != 0);
            e.we   = mem_we_ex;
            e.re   = mem_re_ex;
            e.m2r  = mem_to_reg_ex;
            e.size = mem_size_ex;
            if (con) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
    end

    // Compare process
    always @(negedge clk) begin
        bit     v;
        entry_t h;
        v = (q.size() != 0);
        h = v ? q[0] : '0;
        chk("out_valid", out_valid, v);
        chk("in_ready", in_ready, q.size() < 2);
        chk("reg_write_mem", reg_write_mem, v & h.rw);
        chk("mem_we_mem", mem_we_mem, v & h.we);
        chk("mem_re_mem", mem_re_mem, v & h.re);
        chk("mem_to_reg_mem", mem_to_reg_mem, v & h.m2r);
        chk("fwd_valid", fwd_valid, v & h.rw & ~h.re);
        if (v) begin
            chk("alu_out_mem", alu_out_mem, h.alu);
            chk("rs2_val_mem", rs2_val_mem, h.rs2);
            chk("rd_mem", rd_mem, h.rd);
            chk("mem_size_mem", mem_size_mem, h.size);
            chk("fwd_rd", fwd_rd, h.rd);
            chk("fwd_val", fwd_val, h.alu);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] alu, input logic [RW-1:0] rd,
                         input logic rw, input logic re);
        in_valid      = v;
        alu_out_ex    = alu;
        rs2_val_ex    = ~alu;
        rd_ex         = rd;
        reg_write_ex  = rw;
        mem_we_ex     = 1'b0;
        mem_re_ex     = re;
        mem_to_reg_ex = re;
        mem_size_ex   = 3'b010;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        #2;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_alu_out_mem", alu_out_mem, 32'h0);
        tick();
        rst = 1'b0;
        tick();

        // Streaming: one per cycle, 1-cycle latency
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h10 + i, 5'd1, 1'b1, 1'b0);
            tick();
            chk("stream_alu", alu_out_mem, 32'h10 + i);
            chk("stream_in_ready", in_ready, 1'b1);
        end
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        tick();

        // Backpressure
        out_ready = 1'b0;
        drive(1'b1, 32'hAA, 5'd2, 1'b1, 1'b0); tick();
        drive(1'b1, 32'hBB, 5'd3, 1'b1, 1'b0); tick();
        chk("bp_full_in_ready", in_ready, 1'b0);
        chk("bp_head_A", alu_out_mem, 32'hAA);
        drive(1'b1, 32'hCC, 5'd4, 1'b1, 1'b0); tick();
        chk("bp_hold_A", alu_out_mem, 32'hAA);
        out_ready = 1'b1;
        tick();
        chk("bp_head_B", alu_out_mem, 32'hBB);
        tick();
        chk("bp_head_C", alu_out_mem, 32'hCC);
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        tick();
        chk("bp_drained", out_valid, 1'b0);

        // Flush while full with C presented
        out_ready = 1'b0;
        drive(1'b1, 32'hA1, 5'd2, 1'b1, 1'b0); tick();
        drive(1'b1, 32'hB1, 5'd3, 1'b1, 1'b0); tick();
        drive(1'b1, 32'hC1, 5'd4, 1'b1, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_in_ready", in_ready, 1'b1);
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        out_ready = 1'b1;
        tick();
        chk("flush_no_C", out_valid, 1'b0);

        // x0 write suppression
        drive(1'b1, 32'h55, 5'd0, 1'b1, 1'b0); tick();
        chk("x0_reg_write", reg_write_mem, 1'b0);
        chk("x0_fwd_valid", fwd_valid, 1'b0);
        drive(1'b1, 32'h66, 5'd7, 1'b1, 1'b0); tick();
        chk("x7_reg_write", reg_write_mem, 1'b1);
        chk("x7_fwd_rd", fwd_rd, 5'd7);

        // Load vs ALU forwarding
        drive(1'b1, 32'h100, 5'd5, 1'b1, 1'b1); tick();
        chk("load_fwd_valid", fwd_valid, 1'b0);
        drive(1'b1, 32'h1234, 5'd5, 1'b1, 1'b0); tick();
        chk("alu_fwd_valid", fwd_valid, 1'b1);
        chk("alu_fwd_val", fwd_val, 32'h1234);
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        tick();

        // Asynchronous reset while full and stalled
        out_ready = 1'b0;
        drive(1'b1, 32'hD1, 5'd2, 1'b1, 1'b0); tick();
        drive(1'b1, 32'hD2, 5'd3, 1'b1, 1'b1); tick();
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_in_ready", in_ready, 1'b1);
        chk("arst_alu_out_mem", alu_out_mem, 32'h0);
        chk("arst_rd_mem", rd_mem, 5'd0);
        chk("arst_fwd_valid", fwd_valid, 1'b0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("arst_no_residual", out_valid, 1'b0);
        tick();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            in_valid      = ($urandom_range(0, 3) != 0);
            out_ready     = ($urandom_range(0, 2) != 0);
            alu_out_ex    = $urandom;
            rs2_val_ex    = $urandom;
            rd_ex         = ($urandom_range(0, 3) == 0) ? 5'd0 : RW'($urandom);
            reg_write_ex  = $urandom_range(0, 1);
            mem_we_ex     = $urandom_range(0, 1);
            mem_re_ex     = $urandom_range(0, 1);
            mem_to_reg_ex = $urandom_range(0, 1);
            mem_size_ex   = MW'($urandom);
            flush         = ($urandom_range(0, 15) == 0);
            rst           = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst   = 1'b0;
        flush = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
